// File: rtl/unidad_busqueda.sv
// -----------------------------------------------------------------------------
// unidad_busqueda -- instruction fetch unit
//
// Holds the program counter and fetches one 32-bit word at a time from
// instruction memory over a req/ack handshake. Each fetched word is handed to
// decode over a valid/ready handshake. Taken branches and jumps from the
// control path redirect the PC. A word that was already requested when the
// redirect arrived is discarded when it comes back.
//
// Ports
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   imem_req/imem_addr         fetch request and word address (bits [1:0] = 0)
//   imem_ack/imem_rdata        memory response; rdata is ignored without ack
//   inst_valid/inst_ready      decode handshake
//   inst/inst_opcode/inst_pc4  held instruction, its opcode field, its address + 4
//   branch_taken/branch_target taken-branch redirect
//   jump/jump_index            J-format redirect; target uses inst_pc4[31:28]
// -----------------------------------------------------------------------------
module unidad_busqueda #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [5:0]  inst_opcode,
   output logic [31:0] inst_pc4,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [25:0] jump_index
);

   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

   typedef enum logic {
      FETCH = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] addr_q, addr_d;
   logic        req_q, req_d;
   logic        kill_q, kill_d;
   logic        valid_q, valid_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] pc4_q, pc4_d;

   logic        redirect;
   logic [31:0] target;
   logic [31:0] pc_plus4;
   logic        fetch_ack;

   assign redirect  = branch_taken | jump;
   // Jump has priority over a simultaneous taken branch.
   assign target    = jump ? {pc4_q[31:28], jump_index, 2'b00}
                           : {branch_target[31:2], 2'b00};
   assign pc_plus4  = pc_q + 32'd4;
   // An ack only counts while a request is actually on the bus.
   assign fetch_ack = req_q & imem_ack;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      kill_d  = kill_q;
      valid_d = valid_q;
      inst_d  = inst_q;
      pc4_d   = pc4_q;

      case (state_q)
         FETCH: begin
            if (fetch_ack) begin
               if (redirect) begin
                  // Word arrives together with a redirect: drop it, fetch target.
                  pc_d   = target;
                  kill_d = 1'b0;
               end else if (kill_q) begin
                  // Stale word from before an earlier redirect.
                  kill_d = 1'b0;
               end else begin
                  inst_d  = imem_rdata;
                  pc4_d   = pc_plus4;
                  pc_d    = pc_plus4;
                  valid_d = 1'b1;
                  state_d = HOLD;
               end
            end else if (redirect) begin
               pc_d = target;
               // The outstanding request cannot be retracted; mark its word
               // for discard. With no request yet on the bus nothing is stale.
               kill_d = req_q;
            end
         end
         HOLD: begin
            if (redirect) begin
               // Accept (if ready) completes anyway; the held word is dropped.
               pc_d    = target;
               valid_d = 1'b0;
               state_d = FETCH;
            end else if (inst_ready) begin
               valid_d = 1'b0;
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase

      req_d  = (state_d == FETCH);
      // Address is frozen while a request waits for its ack; otherwise it
      // follows the PC so the next request goes out with the right address.
      addr_d = (req_q && !imem_ack) ? addr_q : pc_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC_ALIGNED;
         addr_q  <= RESET_PC_ALIGNED;
         req_q   <= 1'b0;
         kill_q  <= 1'b0;
         valid_q <= 1'b0;
         inst_q  <= 32'd0;
         pc4_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         req_q   <= req_d;
         kill_q  <= kill_d;
         valid_q <= valid_d;
         inst_q  <= inst_d;
         pc4_q   <= pc4_d;
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = addr_q;
   assign inst_valid  = valid_q;
   assign inst        = inst_q;
   assign inst_opcode = inst_q[31:26];
   assign inst_pc4    = pc4_q;

endmodule

// File: tb/tb_unidad_busqueda.sv
// -----------------------------------------------------------------------------
// tb_unidad_busqueda -- self-checking bench for the fetch unit.
// A transaction-level model (program counter, one open fetch, one held word)
// is advanced on every rising edge; a compare process checks every output on
// every falling edge. Directed scenarios pin the model with literal values,
// then randomized memory latency / ready / redirects / resets exercise it.
// A second instance checks the RESET_PC wrap case and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_unidad_busqueda;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [5:0]  inst_opcode;
   logic [31:0] inst_pc4;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [25:0] jump_index;

   // second instance, RESET_PC at the top of the address space
   logic        rst6_n;
   logic        req6;
   logic [31:0] addr6;
   logic        ack6;
   logic [31:0] rdata6;
   logic        valid6;
   logic        ready6;
   logic [31:0] inst6;
   logic [5:0]  op6;
   logic [31:0] pc4_6;

   always #5 clk = ~clk;

   unidad_busqueda dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst(inst), .inst_opcode(inst_opcode), .inst_pc4(inst_pc4),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .jump_index(jump_index)
   );

   unidad_busqueda #(.RESET_PC(32'hFFFF_FFFC)) u6 (
      .clk(clk), .rst_n(rst6_n),
      .imem_req(req6), .imem_addr(addr6),
      .imem_ack(ack6), .imem_rdata(rdata6),
      .inst_valid(valid6), .inst_ready(ready6),
      .inst(inst6), .inst_opcode(op6), .inst_pc4(pc4_6),
      .branch_taken(1'b0), .branch_target(32'd0),
      .jump(1'b0), .jump_index(26'd0)
   );

   int errors = 0;
   int checks = 0;
   logic chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // instruction memory contents as a function of the address
   function automatic logic [31:0] memf(input logic [31:0] a);
      if (a == 32'd0) return 32'h8C01_0004;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // ---------------- behavioural model ----------------
   logic [31:0] m_pc;      // next address in program order
   logic        m_open;    // a fetch is on the bus
   logic [31:0] m_addr;    // its address
   logic        m_stale;   // its word must be thrown away
   logic        m_valid;
   logic [31:0] m_inst;
   logic [31:0] m_pc4;
   int          accepted = 0;

   task automatic model_reset();
      m_pc = 32'd0; m_addr = 32'd0; m_open = 1'b0; m_stale = 1'b0;
      m_valid = 1'b0; m_inst = 32'd0; m_pc4 = 32'd0;
   endtask

   // called right after each rising edge with the inputs seen at that edge
   task automatic model_update();
      logic        redir;
      logic [31:0] tgt;
      logic        got;
      logic        was_open;
      if (!rst_n) begin
         model_reset();
         return;
      end
      redir    = branch_taken | jump;
      tgt      = jump ? {m_pc4[31:28], jump_index, 2'b00} : (branch_target & 32'hFFFF_FFFC);
      got      = m_open && imem_ack;
      was_open = m_open;
      if (m_valid) begin
         if (inst_ready) accepted++;
         if (redir || inst_ready) m_valid = 1'b0;
         if (redir) m_pc = tgt;
      end else if (got) begin
         if (redir) begin
            m_pc = tgt; m_stale = 1'b0;
         end else if (m_stale) begin
            m_stale = 1'b0;
         end else begin
            m_inst = imem_rdata; m_pc4 = m_addr + 32'd4;
            m_pc = m_addr + 32'd4; m_valid = 1'b1;
         end
      end else if (redir) begin
         m_pc = tgt;
         m_stale = was_open;
      end
      m_open = !m_valid;
      if (!(was_open && !imem_ack)) m_addr = m_pc;
   endtask

   // single compare process
   always @(negedge clk) begin
      if (chk_en) begin
         chk("imem_req", {31'd0, imem_req}, {31'd0, m_open});
         chk("imem_addr", imem_addr, m_addr);
         chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_valid});
         chk("inst", inst, m_inst);
         chk("inst_pc4", inst_pc4, m_pc4);
         chk("inst_opcode", {26'd0, inst_opcode}, {26'd0, m_inst[31:26]});
      end
   end

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic step6();
      @(posedge clk);
      #1;
   endtask

   int lat = -1;

   initial begin
      rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0; inst_ready = 1'b0;
      branch_taken = 1'b0; branch_target = 32'd0; jump = 1'b0; jump_index = 26'd0;
      rst6_n = 1'b0; ack6 = 1'b0; rdata6 = 32'd0; ready6 = 1'b0;
      model_reset();
      chk_en = 1'b1;
      repeat (3) step();

      // T1: reset values, zero-wait memory, ready=1
      chk("T1 rst req", {31'd0, imem_req}, 32'd0);
      chk("T1 rst addr", imem_addr, 32'd0);
      chk("T1 rst valid", {31'd0, inst_valid}, 32'd0);
      rst_n = 1'b1;
      step();
      chk("T1 req0", {31'd0, imem_req}, 32'd1);
      chk("T1 addr0", imem_addr, 32'd0);
      imem_ack = 1'b1; imem_rdata = memf(imem_addr); inst_ready = 1'b1;
      step();
      imem_ack = 1'b0;
      chk("T1 valid", {31'd0, inst_valid}, 32'd1);
      chk("T1 inst", inst, 32'h8C01_0004);
      chk("T1 opcode", {26'd0, inst_opcode}, 32'h23);
      chk("T1 pc4", inst_pc4, 32'd4);
      step();
      chk("T1 addr4", imem_addr, 32'd4);
      imem_ack = 1'b1; imem_rdata = memf(32'd4);
      step();
      imem_ack = 1'b0;
      step();
      chk("T1 addr8", imem_addr, 32'd8);

      // T2: hold with ready low for 5 cycles
      imem_ack = 1'b1; imem_rdata = memf(32'd8); inst_ready = 1'b0;
      step();
      imem_ack = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("T2 inst", inst, memf(32'd8));
         chk("T2 pc4", inst_pc4, 32'h0000_000C);
         chk("T2 req", {31'd0, imem_req}, 32'd0);
         step();
      end

      // T3: branch in HOLD
      branch_taken = 1'b1; branch_target = 32'h43;
      step();
      branch_taken = 1'b0;
      chk("T3 valid", {31'd0, inst_valid}, 32'd0);
      chk("T3 addr", imem_addr, 32'h40);

      // T4: jump during an open fetch, ack three cycles later
      jump = 1'b1; jump_index = 26'h10;
      step();
      jump = 1'b0;
      step(); step();
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      step();
      imem_ack = 1'b0;
      chk("T4 dropped", {31'd0, inst_valid}, 32'd0);
      chk("T4 addr", imem_addr, 32'h40);
      imem_ack = 1'b1; imem_rdata = memf(32'h40);
      step();
      imem_ack = 1'b0;
      chk("T4 inst", inst, memf(32'h40));

      // T5: jump and branch together in HOLD
      jump = 1'b1; jump_index = 26'h20; branch_taken = 1'b1; branch_target = 32'h80;
      step();
      chk("T5 addr", imem_addr, 32'h80);
      imem_ack = 1'b1; imem_rdata = memf(32'h80); jump = 1'b0; branch_taken = 1'b0;
      step();
      imem_ack = 1'b0;
      // jump must beat a different branch target; ready in the same cycle
      jump = 1'b1; jump_index = 26'h30; branch_taken = 1'b1; branch_target = 32'h100;
      inst_ready = 1'b1;
      step();
      jump = 1'b0; branch_taken = 1'b0;
      chk("T5b addr", imem_addr, 32'hC0);
      chk("T5b valid", {31'd0, inst_valid}, 32'd0);

      // randomized phase
      for (int i = 0; i < 4000; i++) begin
         step();
         if (!rst_n) begin
            rst_n = 1'b1;
         end else if ($urandom_range(0, 399) == 0) begin
            rst_n = 1'b0;
            model_reset();
            lat = -1;
         end
         if (imem_req && rst_n) begin
            if (lat < 0) lat = $urandom_range(0, 3);
            imem_ack = (lat == 0);
            if (imem_ack) lat = -1; else lat--;
         end else begin
            imem_ack = 1'b0;
            lat = -1;
         end
         imem_rdata    = imem_ack ? memf(imem_addr) : $urandom;
         inst_ready    = ($urandom_range(0, 3) != 0);
         branch_taken  = ($urandom_range(0, 9) == 0);
         branch_target = $urandom;
         jump          = ($urandom_range(0, 13) == 0);
         jump_index    = 26'($urandom);
      end
      rst_n = 1'b1; imem_ack = 1'b0; branch_taken = 1'b0; jump = 1'b0; inst_ready = 1'b0;
      checks++;
      if (accepted < 100) begin
         errors++;
         $display("FAIL progress: got %0d accepted expected at least 100", accepted);
      end

      // T6: RESET_PC = 0xFFFFFFFC wraps, then asynchronous reset mid-fetch
      rst6_n = 1'b1;
      step6();
      chk("T6 req", {31'd0, req6}, 32'd1);
      chk("T6 addr", addr6, 32'hFFFF_FFFC);
      ack6 = 1'b1; rdata6 = 32'h1234_5678; ready6 = 1'b0;
      step6();
      ack6 = 1'b0;
      chk("T6 valid", {31'd0, valid6}, 32'd1);
      chk("T6 inst", inst6, 32'h1234_5678);
      chk("T6 pc4", pc4_6, 32'd0);
      ready6 = 1'b1;
      step6();
      chk("T6 next addr", addr6, 32'd0);
      chk("T6 next req", {31'd0, req6}, 32'd1);
      #2;
      rst6_n = 1'b0;
      #1;
      chk("T6 async req", {31'd0, req6}, 32'd0);
      chk("T6 async addr", addr6, 32'hFFFF_FFFC);
      chk("T6 async pc4", pc4_6, 32'd0);
      step6();

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
